// File: rtl/axi_lite_reg_poller_pkg.sv
// axi_lite_reg_poller_pkg: shared FSM states, AXI4-Lite response codes and bus widths.
package axi_lite_reg_poller_pkg;
  localparam int AxiAddrWidth = 16;
  localparam int AxiDataWidth = 32;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;
  typedef enum logic [1:0] {StIdle, StAddr, StData, StWait} pollState_e;
endpackage

// File: rtl/axi_lite_reg_poller.sv
// axi_lite_reg_poller: periodically reads one AXI4-Lite register and holds the last good value.
module axi_lite_reg_poller
  import axi_lite_reg_poller_pkg::*;
#(
  parameter logic [AxiAddrWidth-1:0] RegAddress_Gen = 16'h0000,
  parameter int unsigned PollPeriod_Gen = 1000,
  parameter int unsigned TimeoutCycles_Gen = 256
) (
  input  logic                    SysClk_ClkIn,
  input  logic                    SysRstN_RstIn,
  input  logic                    Enable_EnaIn,
  output logic                    AxiReadAddrValid_ValOut,
  input  logic                    AxiReadAddrReady_RdyIn,
  output logic [AxiAddrWidth-1:0] AxiReadAddrAddress_AdrOut,
  output logic [2:0]              AxiReadAddrProt_DatOut,
  input  logic                    AxiReadDataValid_ValIn,
  output logic                    AxiReadDataReady_RdyOut,
  input  logic [1:0]              AxiReadDataResponse_DatIn,
  input  logic [AxiDataWidth-1:0] AxiReadDataData_DatIn,
  output logic [AxiDataWidth-1:0] RegValue_DatOut,
  output logic                    RegValid_ValOut,
  output logic                    ReadDone_EvtOut,
  output logic [1:0]              RespError_DatOut,
  output logic                    Timeout_FlgOut
);
  localparam logic [19:0] PollLoad = 20'(PollPeriod_Gen);
  localparam logic [15:0] TimeoutMax = 16'(TimeoutCycles_Gen);
  pollState_e state, stateNxt;
  logic armed;
  logic [19:0] waitCnt, waitCntNxt;
  logic [15:0] toCnt, toCntNxt;
  logic readDoneNxt, regValidNxt, timeoutNxt;
  logic [1:0] respErrNxt;
  logic [AxiDataWidth-1:0] regValueNxt;
  assign AxiReadAddrAddress_AdrOut = RegAddress_Gen;
  assign AxiReadAddrProt_DatOut = 3'b000;
  always_comb begin
    stateNxt = state;
    waitCntNxt = waitCnt;
    toCntNxt = toCnt;
    readDoneNxt = 1'b0;
    respErrNxt = RespError_DatOut;
    regValueNxt = RegValue_DatOut;
    regValidNxt = RegValid_ValOut;
    timeoutNxt = Timeout_FlgOut;
    if (state == StAddr || state == StData) begin
      toCntNxt = (toCnt == TimeoutMax) ? toCnt : toCnt + 16'd1;
      timeoutNxt = (toCntNxt == TimeoutMax) ? 1'b1 : Timeout_FlgOut;
    end
    case (state)
      StIdle: if (armed && Enable_EnaIn) begin
        stateNxt = StAddr;
        toCntNxt = '0;
      end
      StAddr: stateNxt = AxiReadAddrReady_RdyIn ? StData : StAddr;
      StData: if (AxiReadDataValid_ValIn) begin
        stateNxt = StWait;
        waitCntNxt = PollLoad;
        readDoneNxt = 1'b1;
        respErrNxt = AxiReadDataResponse_DatIn;
        // an OKAY read is proof the slave is alive again, so it clears the timeout flag
        if (AxiReadDataResponse_DatIn == RespOkay) begin
          regValueNxt = AxiReadDataData_DatIn;
          regValidNxt = 1'b1;
          timeoutNxt = 1'b0;
        end
      end
      StWait: begin
        waitCntNxt = waitCnt - 20'd1;
        if (!Enable_EnaIn || waitCnt == 20'd1) begin
          stateNxt = Enable_EnaIn ? StAddr : StIdle;
          toCntNxt = '0;
        end
      end
    endcase
  end
  // armed holds off the first poll until the second edge after reset release
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn)
    if (!SysRstN_RstIn) begin
      state <= StIdle;
      armed <= 1'b0;
      waitCnt <= '0;
      toCnt <= '0;
      AxiReadAddrValid_ValOut <= 1'b0;
      AxiReadDataReady_RdyOut <= 1'b0;
      RegValue_DatOut <= '0;
      RegValid_ValOut <= 1'b0;
      ReadDone_EvtOut <= 1'b0;
      RespError_DatOut <= RespOkay;
      Timeout_FlgOut <= 1'b0;
    end else begin
      state <= stateNxt;
      armed <= 1'b1;
      waitCnt <= waitCntNxt;
      toCnt <= toCntNxt;
      AxiReadAddrValid_ValOut <= stateNxt == StAddr;
      AxiReadDataReady_RdyOut <= stateNxt == StData;
      RegValue_DatOut <= regValueNxt;
      RegValid_ValOut <= regValidNxt;
      ReadDone_EvtOut <= readDoneNxt;
      RespError_DatOut <= respErrNxt;
      Timeout_FlgOut <= timeoutNxt;
    end
endmodule

// File: tb/tb_axi_lite_reg_poller.sv
// tb_axi_lite_reg_poller: randomized slave stimulus checked against a transaction-level model.
module tb_axi_lite_reg_poller;
  import axi_lite_reg_poller_pkg::*;
  localparam logic [15:0] RegAddr = 16'hA5C4;
  localparam int Period = 4;
  localparam int ToCycles = 16;
  logic clk = 1'b0, rstN = 1'b0, enable = 1'b0, arReady = 1'b0, rValid = 1'b0;
  logic [1:0] rResp = 2'b00;
  logic [31:0] rData = '0;
  logic arValid, rReady, regValid, readDone, timeout;
  logic [15:0] arAddr;
  logic [2:0] arProt;
  logic [31:0] regValue;
  logic [1:0] respErr;
  int nAssert = 0, nFail = 0;
  logic [31:0] mValue = '0;
  logic mValid = 1'b0, mTimeout = 1'b0;

  always #5 clk = ~clk;

  axi_lite_reg_poller #(.RegAddress_Gen(RegAddr), .PollPeriod_Gen(Period), .TimeoutCycles_Gen(ToCycles)) dut (
    .SysClk_ClkIn(clk), .SysRstN_RstIn(rstN), .Enable_EnaIn(enable),
    .AxiReadAddrValid_ValOut(arValid), .AxiReadAddrReady_RdyIn(arReady),
    .AxiReadAddrAddress_AdrOut(arAddr), .AxiReadAddrProt_DatOut(arProt),
    .AxiReadDataValid_ValIn(rValid), .AxiReadDataReady_RdyOut(rReady),
    .AxiReadDataResponse_DatIn(rResp), .AxiReadDataData_DatIn(rData),
    .RegValue_DatOut(regValue), .RegValid_ValOut(regValid), .ReadDone_EvtOut(readDone),
    .RespError_DatOut(respErr), .Timeout_FlgOut(timeout));

  task automatic waitArValid(input int expectGap);
    int n = 0;
    while (arValid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      nAssert++;
      if ({rReady, readDone, timeout} !== {1'b0, 1'b0, mTimeout}) begin
        nFail++;
        $display("FAIL idle_outputs: rready/done/timeout got %b%b%b want 00%b", rReady, readDone, timeout, mTimeout);
      end
    end
    nAssert++;
    if (arValid !== 1'b1 || n !== expectGap) begin
      nFail++;
      $display("FAIL arvalid_gap: got arvalid=%b after %0d cycles want 1 after %0d", arValid, n, expectGap);
    end
  endtask

  task automatic doRead(input int arDelay, input int rDelay, input logic [1:0] resp, input logic [31:0] data,
                        input bit dropEn, input bit rstData);
    int k = 0;
    for (int i = 0; i <= arDelay; i++) begin
      nAssert++;
      if ({arValid, rReady, arAddr, arProt} !== {1'b1, 1'b0, RegAddr, 3'b000}) begin
        nFail++;
        $display("FAIL addr_phase: arvalid/rready/araddr got %b/%b/%h want 1/0/%h", arValid, rReady, arAddr, RegAddr);
      end
      nAssert++;
      if (timeout !== (mTimeout | (k >= ToCycles))) begin
        nFail++;
        $display("FAIL timeout_addr: got %b want %b at cycle %0d", timeout, mTimeout | (k >= ToCycles), k);
      end
      if (dropEn && i == 0) enable = 1'b0;
      arReady = (i == arDelay);
      rValid = (i == arDelay);
      rResp = RespOkay;
      rData = 32'hDEAD_BEEF;
      @(negedge clk);
      k++;
    end
    arReady = 1'b0;
    rValid = 1'b0;
    if (rstData) begin
      nAssert++;
      if (rReady !== 1'b1) begin
        nFail++;
        $display("FAIL rready_before_reset: got %b want 1", rReady);
      end
      rstN = 1'b0;
      #1;
      mValue = '0;
      mValid = 1'b0;
      mTimeout = 1'b0;
      nAssert++;
      if ({arValid, rReady, regValue, regValid, readDone, respErr, timeout} !== 39'd0) begin
        nFail++;
        $display("FAIL reset_in_data: got av=%b rr=%b val=%h vld=%b done=%b err=%b to=%b want all 0",
                 arValid, rReady, regValue, regValid, readDone, respErr, timeout);
      end
      return;
    end
    for (int j = 0; j <= rDelay; j++) begin
      nAssert++;
      if ({arValid, rReady, readDone} !== 3'b010) begin
        nFail++;
        $display("FAIL data_phase: arvalid/rready/done got %b%b%b want 010", arValid, rReady, readDone);
      end
      nAssert++;
      if (timeout !== (mTimeout | (k >= ToCycles))) begin
        nFail++;
        $display("FAIL timeout_data: got %b want %b at cycle %0d", timeout, mTimeout | (k >= ToCycles), k);
      end
      rValid = (j == rDelay);
      rData = data;
      rResp = resp;
      @(negedge clk);
      k++;
    end
    rValid = 1'b0;
    rData = $urandom;
    if (resp == RespOkay) begin
      mValue = data;
      mValid = 1'b1;
      mTimeout = 1'b0;
    end else mTimeout = mTimeout | (k >= ToCycles);
    nAssert++;
    if ({arValid, rReady, readDone, respErr} !== {1'b0, 1'b0, 1'b1, resp}) begin
      nFail++;
      $display("FAIL completion: av/rr/done/err got %b/%b/%b/%b want 0/0/1/%b", arValid, rReady, readDone, respErr, resp);
    end
    nAssert++;
    if ({regValue, regValid, timeout} !== {mValue, mValid, mTimeout}) begin
      nFail++;
      $display("FAIL result: value/valid/timeout got %h/%b/%b want %h/%b/%b",
               regValue, regValid, timeout, mValue, mValid, mTimeout);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    nAssert++;
    if ({arValid, rReady, regValue, regValid, readDone, respErr, timeout, arProt, arAddr} !== {42'd0, RegAddr}) begin
      nFail++;
      $display("FAIL reset_state: av=%b rr=%b val=%h vld=%b done=%b err=%b to=%b prot=%b addr=%h",
               arValid, rReady, regValue, regValid, readDone, respErr, timeout, arProt, arAddr);
    end
    rstN = 1'b1;
    repeat (4) begin
      @(negedge clk);
      nAssert++;
      if (arValid !== 1'b0) begin
        nFail++;
        $display("FAIL disabled_idle: arvalid got %b want 0", arValid);
      end
    end
    enable = 1'b1;
    waitArValid(1);
  endtask

  task automatic test_base_read();
    doRead(0, 0, RespOkay, 32'h0102_0304, 0, 0);
    waitArValid(Period);
  endtask

  task automatic test_backpressure();
    doRead(7, 2, RespOkay, $urandom, 0, 0);
    waitArValid(Period);
  endtask

  task automatic test_error_response();
    doRead(0, 0, RespOkay, 32'hAAAA_5555, 0, 0);
    waitArValid(Period);
    doRead(0, 0, RespSlvErr, 32'hFFFF_FFFF, 0, 0);
    waitArValid(Period);
  endtask

  task automatic test_timeout();
    doRead(0, 38, RespOkay, $urandom, 0, 0);
    waitArValid(Period);
    doRead(3, 20, RespDecErr, $urandom, 0, 0);
    waitArValid(Period);
    doRead(0, 0, RespExOkay, $urandom, 0, 0);
    waitArValid(Period);
    doRead(0, 1, RespOkay, $urandom, 0, 0);
    waitArValid(Period);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 10; t++) begin
      doRead(int'($urandom_range(0, 4)), int'($urandom_range(0, 18)), 2'($urandom), $urandom, 0, 0);
      waitArValid(Period);
    end
  endtask

  task automatic test_enable_drop();
    doRead(1, 1, RespOkay, $urandom, 1, 0);
    repeat (20) begin
      @(negedge clk);
      nAssert++;
      if ({arValid, readDone} !== 2'b00) begin
        nFail++;
        $display("FAIL no_poll_after_drop: arvalid/done got %b%b want 00", arValid, readDone);
      end
    end
    enable = 1'b1;
    waitArValid(1);
    doRead(0, 0, RespOkay, $urandom, 0, 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    waitArValid(1);
  endtask

  task automatic test_reset_in_data();
    doRead(0, 0, RespOkay, $urandom, 0, 1);
    repeat (3) begin
      @(negedge clk);
      nAssert++;
      if ({arValid, rReady} !== 2'b00) begin
        nFail++;
        $display("FAIL held_in_reset: arvalid/rready got %b%b want 00", arValid, rReady);
      end
    end
    rstN = 1'b1;
    waitArValid(2);
    doRead(0, 0, RespOkay, $urandom, 0, 0);
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_base_read();
    test_backpressure();
    test_error_response();
    test_timeout();
    test_back_to_back();
    test_enable_drop();
    test_reset_in_data();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_lite_reg_poller.md
AXI_LITE_REG_POLLER -- requirements
Module: axi_lite_reg_poller

Interface
REQ-001 Parameters (name, default, meaning): RegAddress_Gen, 16'h0000, byte address read on every poll.
REQ-002 PollPeriod_Gen, 1000, idle cycles between polls; legal range 1..2^20-1.
REQ-003 TimeoutCycles_Gen, 256, cycles after a read starts before the timeout flag sets; legal range 2..2^16-1.
REQ-004 Port (name, direction, width, meaning): SysClk_ClkIn, in, 1, system clock; the only clock.
REQ-005 SysRstN_RstIn, in, 1, reset; asynchronous and active-low.
REQ-006 Enable_EnaIn, in, 1, polling enable.
REQ-007 AxiReadAddrValid_ValOut, out, 1, ARVALID.
REQ-008 AxiReadAddrReady_RdyIn, in, 1, ARREADY.
REQ-009 AxiReadAddrAddress_AdrOut, out, 16, ARADDR.
REQ-010 AxiReadAddrProt_DatOut, out, 3, ARPROT; constant 3'b000.
REQ-011 AxiReadDataValid_ValIn, in, 1, RVALID.
REQ-012 AxiReadDataReady_RdyOut, out, 1, RREADY.
REQ-013 AxiReadDataResponse_DatIn, in, 2, RRESP.
REQ-014 AxiReadDataData_DatIn, in, 32, RDATA.
REQ-015 RegValue_DatOut, out, 32, last value read with an OKAY response.
REQ-016 RegValid_ValOut, out, 1, RegValue holds at least one OKAY read.
REQ-017 ReadDone_EvtOut, out, 1, one-cycle pulse per completed read.
REQ-018 RespError_DatOut, out, 2, RRESP of the last completed read.
REQ-019 Timeout_FlgOut, out, 1, sticky: the current or a previous read exceeded TimeoutCycles_Gen.

Function
REQ-020 States: IDLE, ADDR, DATA, WAIT.
REQ-021 IDLE: when Enable is sampled high, the block moves to ADDR; ARVALID is high in the next cycle, with ARADDR=RegAddress_Gen.
REQ-022 ADDR: ARVALID is held high, and ARADDR stable, until the cycle with ARVALID&ARREADY; it is never dropped before that, even if Enable falls.
REQ-023 Address handshake: the next cycle is DATA, with ARVALID=0 and RREADY=1; RREADY is high only in DATA.
REQ-024 DATA: the cycle with RVALID&RREADY completes the read.
REQ-025 Completion, next cycle: ReadDone_EvtOut=1 for one cycle, RespError updated, RREADY=0, state WAIT.
REQ-026 If the completing RRESP==OKAY: RegValue<=RDATA, RegValid<=1, Timeout_FlgOut cleared.
REQ-027 If RRESP!=OKAY: RegValue and RegValid keep their values; Timeout_FlgOut is unchanged.
REQ-028 WAIT: a down-counter loaded with PollPeriod_Gen; at 0, go to ADDR if Enable=1, else IDLE.
REQ-029 Poll timing: ARVALID rises exactly PollPeriod_Gen+1 cycles after the R handshake cycle.
REQ-030 Enable low during WAIT: abort WAIT and go to IDLE next cycle; no ARVALID is issued.
REQ-031 Timeout counter: cleared on entry to ADDR; increments each cycle in ADDR and DATA; saturates at TimeoutCycles_Gen.
REQ-032 When the timeout counter reaches TimeoutCycles_Gen, Timeout_FlgOut sets.
REQ-033 A timeout does not abort the transaction; the handshake still completes per AXI4-Lite rules.
REQ-034 RVALID arriving in the same cycle as the AR handshake is not accepted, because RREADY=0 in ADDR.
REQ-035 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-036 On reset assertion, immediately: state IDLE, ARVALID=0, RREADY=0, RegValue=0, RegValid=0, ReadDone=0, RespError=2'b00, Timeout=0, all counters 0.
REQ-037 Reset mid-transaction discards the transaction; after release, the block restarts from IDLE.
REQ-038 Reset release is synchronised externally; the first ARVALID is no earlier than the second clock edge after release.

Structure
REQ-039 Shared package: state enum, RRESP constants (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11), and the AXI address and data width constants 16 and 32.
REQ-040 Single module; no sub-module. Both counters are inline.
REQ-041 The block connects directly to the read channel of the version-register AXI4-Lite slave; its write channel is tied off by the integrator.

Verification
REQ-042 Base read: PollPeriod=4, slave ARREADY=1, RVALID one cycle later, RDATA=32'h0102_0304, OKAY -> RegValue=32'h0102_0304, RegValid=1, one ReadDone pulse; next ARVALID 5 cycles after the R handshake.
REQ-043 Backpressure: ARREADY delayed 7 cycles -> ARVALID and ARADDR stable for all 7 cycles; RREADY stays 0 until the handshake.
REQ-044 Error response: first read OKAY 32'hAAAA_5555, second read SLVERR 32'hFFFF_FFFF -> RegValue stays 32'hAAAA_5555, RespError=2'b10, ReadDone pulses twice.
REQ-045 Timeout: TimeoutCycles=16, RVALID delayed 40 cycles -> Timeout_FlgOut set after 16 cycles, read completes at 40, flag clears on that OKAY read.
REQ-046 Enable drop: Enable falls in ADDR -> the transaction completes, then the block enters IDLE with no further ARVALID. Enable falls in WAIT -> IDLE next cycle.
REQ-047 Reset in DATA: assert reset while RREADY=1 -> all outputs take their reset values immediately; with Enable=1 after release, a fresh poll issues ARVALID.
